// File: rtl/sha2_block_seq.sv
// Block sequencer for a SHA-2 core: assembles 32 16-bit words into a 512-bit block,
// starts the core with init/next pulses, and supervises each block with a timeout.
module sha2_block_seq #(
    parameter logic       MODE    = 1'b1,
    parameter logic [7:0] TIMEOUT = 8'd128
) (
    input  logic         mclk,
    input  logic         puc_rst,
    input  logic         in_valid,
    input  logic [15:0]  in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic         core_digest_valid,
    output logic         msg_done,
    output logic         err,
    output logic         busy,
    output logic [7:0]   blk_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_DONE} state_t;

    state_t     state, state_d;
    logic [4:0] word_cnt;
    logic [4:0] wr_idx;
    logic [7:0] timer;
    logic       first, last;
    logic       xfer, err_set, timer_hit, bad_last;

    assign core_mode = MODE;
    assign in_ready  = (state == S_IDLE) || (state == S_FILL);
    assign busy      = (state != S_IDLE);
    assign xfer      = in_valid && in_ready;
    assign timer_hit = (timer == TIMEOUT - 8'd1);
    // IDLE always writes word 0, whatever the counter holds.
    assign wr_idx    = (state == S_IDLE) ? 5'd0 : word_cnt;
    assign bad_last  = in_last && (wr_idx != 5'd31);

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state;
        err_set   = 1'b0;
        core_init = 1'b0;
        core_next = 1'b0;
        msg_done  = 1'b0;
        case (state)
            S_IDLE, S_FILL: begin
                if (xfer) begin
                    if (bad_last) begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end else if (wr_idx == 5'd31) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_START: begin
                core_init = first;
                core_next = !first;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle ignores core_ready: the core has not yet dropped it.
                if (timer != 8'd0 && core_ready) begin
                    state_d = last ? S_DONE : S_FILL;
                end else if (timer_hit) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (core_digest_valid) begin
                    msg_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (timer_hit) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge mclk) begin
        if (puc_rst) state <= S_IDLE;
        else         state <= state_d;
    end

    // NOTE: the block register is wide but still cleared on reset, so a stale message never leaks out.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            core_block <= '0;
            word_cnt   <= '0;
            timer      <= '0;
            blk_cnt    <= '0;
            first      <= 1'b0;
            last       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= err_set;

            if (state_d != state)
                timer <= '0;
            else if (state == S_WAIT || state == S_DONE)
                timer <= timer + 8'd1;

            if (xfer) begin
                if (bad_last) begin
                    word_cnt <= '0;
                end else begin
                    core_block[{wr_idx, 4'b0000} +: 16] <= in_data;
                    word_cnt <= wr_idx + 5'd1;
                    if (wr_idx == 5'd31)
                        last <= in_last;
                    if (state == S_IDLE) begin
                        first   <= 1'b1;
                        blk_cnt <= '0;
                    end
                end
            end

            if (state == S_START)
                blk_cnt <= blk_cnt + 8'd1;

            if (state == S_WAIT && state_d != S_WAIT && !err_set) begin
                first    <= 1'b0;
                word_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/sha2_block_seq.md
SHA2_BLOCK_SEQ -- requirements
Module: sha2_block_seq

Interface
REQ-001 SHALL have parameter MODE, default 1'b1, SHA mode driven on core_mode (1 = SHA-256, 0 = SHA-224).
REQ-002 SHALL have parameter TIMEOUT, default 8'd128, maximum cycles spent in WAIT before error.
REQ-003 mclk  input  1  main system clock; all logic on its rising edge.
REQ-004 puc_rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  requester word valid.
REQ-006 in_data  input  16  message word; padding is already applied by software.
REQ-007 in_last  input  1  qualifies the final word of the final block.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 core_init  output  1  one-cycle start pulse for the first block of a message.
REQ-010 core_next  output  1  one-cycle start pulse for each subsequent block.
REQ-011 core_mode  output  1  equals MODE.
REQ-012 core_block  output  512  assembled block.
REQ-013 core_ready  input  1  core idle.
REQ-014 core_digest_valid  input  1  core digest valid.
REQ-015 msg_done  output  1  one-cycle pulse when the final digest is valid.
REQ-016 err  output  1  one-cycle error pulse.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 blk_cnt  output  8  blocks issued for the current message; wraps 255 -> 0.

Function
REQ-019 States SHALL be IDLE, FILL, START, WAIT and DONE.
REQ-020 A word SHALL transfer on a cycle where in_valid & in_ready are both high.
REQ-021 in_ready SHALL be 1 only in IDLE and FILL.
REQ-022 Word k (0..31) of a block SHALL be written to core_block[16k +: 16].
REQ-023 A 5-bit word counter SHALL advance per transfer.
REQ-024 IDLE: a transfer SHALL store word 0, set first=1, clear blk_cnt, and go to FILL.
REQ-025 FILL: transfer of word 31 SHALL go to START and latch last=in_last.
REQ-026 A transfer with in_last=1 at word index other than 31 (including in IDLE) SHALL pulse err, clear the counter, and go to IDLE with no core pulse.
REQ-027 START: exactly one cycle; SHALL assert core_init if first=1, else core_next; blk_cnt SHALL increment; next state is WAIT.
REQ-028 WAIT cycle 1: core_ready SHALL be ignored (guard cycle for core ready latency).
REQ-029 WAIT, later cycles: core_ready=1 SHALL clear first, reset the counter, and go to DONE if last=1, else FILL.
REQ-030 WAIT: a cycle counter reaching TIMEOUT SHALL pulse err and go to IDLE.
REQ-031 DONE: msg_done SHALL pulse in the first cycle with core_digest_valid=1, then go to IDLE.
REQ-032 DONE: if core_digest_valid=0 for TIMEOUT cycles, SHALL pulse err and go to IDLE.
REQ-033 core_block SHALL be stable from START until WAIT exits; no word is accepted meanwhile.
REQ-034 core_init and core_next SHALL never be high together, nor for more than one cycle.

Reset
REQ-035 puc_rst=1 SHALL, on the next edge, force IDLE and zero core_block, counters, blk_cnt, first, last, core_init, core_next, msg_done and err, from any state, including mid-WAIT.
REQ-036 After reset release, in_ready SHALL be 1 in the first cycle.

Verification
REQ-037 Single block "abc" (padded 32 words, in_last on word 31) -> exactly one core_init, then msg_done; digest = ba7816bf...f20015ad; blk_cnt=1.
REQ-038 Two-block 56-byte message "abcdbcde...nopq" -> core_init then core_next; msg_done once; blk_cnt=2; digest 248d6a61...19db06c1.
REQ-039 in_last asserted on word 10 -> err pulse; no core_init; FSM in IDLE; in_ready=1 next cycle.
REQ-040 Core model holds core_ready=0 for 200 cycles -> err exactly 128 cycles after WAIT entry; no msg_done.
REQ-041 puc_rst in WAIT -> IDLE, core_block=0, busy=0; a following single-block message completes normally.
REQ-042 Random in_valid gaps (50% duty) -> same digest as REQ-037; in_ready=0 throughout START, WAIT and DONE.
